rf_scoreboard: RTL and testbench



---
 rtl/rf_scoreboard.sv | 116 +++++++++++
 tb/tb_rf_scoreboard.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: issue-side hazard tracker for the 16x16 register file.
// Keeps one outstanding-writer counter per architectural register, stalls
// issue on in-flight sources or saturated destinations, flags writebacks to
// idle registers and counts stalled issue cycles.
module rf_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_vld,
    input  logic [3:0]  iss_src0,
    input  logic        iss_src0_vld,
    input  logic [3:0]  iss_src1,
    input  logic        iss_src1_vld,
    input  logic [3:0]  iss_dst,
    input  logic        iss_dst_vld,
    output logic        iss_stall,
    input  logic        wb_we,
    input  logic [3:0]  wb_addr,
    output logic [15:0] busy_vec,
    output logic        wb_err,
    output logic [15:0] stall_cnt
);

    localparam int unsigned NREG   = 16;
    localparam int unsigned SCNT_W = 16;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = '1;

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              wb_err_q, wb_err_d;
    logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NREG-1:0]   wb_hit;
    logic              src0_haz, src1_haz, dst_haz;
    logic              accept;

    // One-hot decode of a writeback that retires a tracked register.
    always_comb begin
        wb_hit = '0;
        if (wb_we && (wb_addr != 4'd0)) begin
            wb_hit[wb_addr] = 1'b1;
        end
    end

    // Hazard detection; the last in-flight writer landing this cycle is forwarded by the RF.
    always_comb begin
        src0_haz = iss_src0_vld && (iss_src0 != 4'd0) && (cnt_q[iss_src0] != '0)
                   && !((cnt_q[iss_src0] == CNT_ONE) && wb_hit[iss_src0]);
        src1_haz = iss_src1_vld && (iss_src1 != 4'd0) && (cnt_q[iss_src1] != '0)
                   && !((cnt_q[iss_src1] == CNT_ONE) && wb_hit[iss_src1]);
        dst_haz  = iss_dst_vld && (iss_dst != 4'd0) && (cnt_q[iss_dst] == CNT_MAX)
                   && !wb_hit[iss_dst];
        iss_stall = iss_vld && (src0_haz || src1_haz || dst_haz);
        accept    = iss_vld && !iss_stall;
    end

    // Per-register counter update; register 0 is never tracked.
    always_comb begin
        logic inc;
        logic dec;
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            inc      = accept && iss_dst_vld && (iss_dst == 4'(r));
            dec      = wb_hit[r] && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    // Sticky illegal-writeback flag and saturating stall statistic.
    always_comb begin
        wb_err_d = wb_err_q;
        if (wb_we && (wb_addr != 4'd0) && (cnt_q[wb_addr] == '0)) begin
            wb_err_d = 1'b1;
        end
        stall_cnt_d = stall_cnt_q;
        if (iss_stall && (stall_cnt_q != SCNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + SCNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            wb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            wb_err_q    <= wb_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Busy view derived purely from the counter flops.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    assign wb_err    = wb_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Testbench for rf_scoreboard: directed scenarios plus random traffic,
// checked against a counter-per-register reference model via an expectation queue.
module tb_rf_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_vld = 1'b0;
    logic [3:0]  iss_src0 = '0;
    logic        iss_src0_vld = 1'b0;
    logic [3:0]  iss_src1 = '0;
    logic        iss_src1_vld = 1'b0;
    logic [3:0]  iss_dst = '0;
    logic        iss_dst_vld = 1'b0;
    logic        iss_stall;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [15:0] busy_vec;
    logic        wb_err;
    logic [15:0] stall_cnt;

    rf_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .iss_vld(iss_vld),
        .iss_src0(iss_src0), .iss_src0_vld(iss_src0_vld),
        .iss_src1(iss_src1), .iss_src1_vld(iss_src1_vld),
        .iss_dst(iss_dst), .iss_dst_vld(iss_dst_vld),
        .iss_stall(iss_stall),
        .wb_we(wb_we), .wb_addr(wb_addr),
        .busy_vec(busy_vec), .wb_err(wb_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic [15:0] busy;
        logic        err;
        logic [15:0] scnt;
        logic [31:0] id;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    // Reference model: outstanding writers per register as plain integers.
    int mcnt [16];
    bit merr;
    int mscnt;
    localparam int MAXCNT = 3;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mcnt[i] = 0;
        merr  = 0;
        mscnt = 0;
    endfunction

    function automatic bit wb_lands(input int r);
        return wb_we && (int'(wb_addr) == r) && (r != 0);
    endfunction

    function automatic bit src_blocked(input bit v, input int r);
        if (!v || r == 0 || mcnt[r] == 0) return 0;
        if (mcnt[r] == 1 && wb_lands(r)) return 0;
        return 1;
    endfunction

    function automatic bit model_stall();
        int d;
        bit dh;
        if (!iss_vld) return 0;
        d  = int'(iss_dst);
        dh = iss_dst_vld && d != 0 && mcnt[d] == MAXCNT && !wb_lands(d);
        return src_blocked(iss_src0_vld, int'(iss_src0)) ||
               src_blocked(iss_src1_vld, int'(iss_src1)) || dh;
    endfunction

    function automatic logic [15:0] model_busy();
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[i] = (mcnt[i] != 0);
        return b;
    endfunction

    // Advance the model across one rising edge given the stall decision of this cycle.
    function automatic void model_edge(input bit stall);
        int  a;
        bit  dec;
        a   = int'(wb_addr);
        dec = 0;
        if (wb_we && a != 0) begin
            if (mcnt[a] == 0) merr = 1;
            else dec = 1;
        end
        if (iss_vld && stall && mscnt < 65535) mscnt++;
        if (iss_vld && !stall && iss_dst_vld && iss_dst != 4'd0) mcnt[int'(iss_dst)]++;
        if (dec) mcnt[a]--;
    endfunction

    task automatic push_exp(input bit stall);
        exp_t e;
        e.stall = stall;
        e.busy  = model_busy();
        e.err   = merr;
        e.scnt  = 16'(mscnt);
        e.id    = 32'(step_id);
        expq.push_back(e);
    endtask

    // One clock cycle with the currently driven inputs; optionally queue an expectation.
    task automatic tick(input bit chk);
        bit s;
        s = model_stall();
        if (chk) push_exp(s);
        step_id++;
        @(posedge clk);
        model_edge(s);
        #1;
    endtask

    task automatic set_iss(input bit v, input int s0, input bit s0v,
                           input int s1, input bit s1v, input int d, input bit dv);
        iss_vld      = v;
        iss_src0     = 4'(s0);
        iss_src0_vld = s0v;
        iss_src1     = 4'(s1);
        iss_src1_vld = s1v;
        iss_dst      = 4'(d);
        iss_dst_vld  = dv;
    endtask

    task automatic set_wb(input bit we, input int a);
        wb_we   = we;
        wb_addr = 4'(a);
    endtask

    task automatic idle();
        set_iss(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0);
    endtask

    // Asynchronous reset raised between clock edges, checked while still asserted.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        push_exp(1'b0);
        step_id++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            checks += 4;
            if (iss_stall !== e.stall) begin
                errors++;
                $display("FAIL iss_stall step=%0d got=%b exp=%b", e.id, iss_stall, e.stall);
            end
            if (busy_vec !== e.busy) begin
                errors++;
                $display("FAIL busy_vec step=%0d got=%h exp=%h", e.id, busy_vec, e.busy);
            end
            if (wb_err !== e.err) begin
                errors++;
                $display("FAIL wb_err step=%0d got=%b exp=%b", e.id, wb_err, e.err);
            end
            if (stall_cnt !== e.scnt) begin
                errors++;
                $display("FAIL stall_cnt step=%0d got=%h exp=%h", e.id, stall_cnt, e.scnt);
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single writer tracked then retired.
        idle(); set_iss(1, 0, 0, 0, 0, 5, 1); tick(1);
        idle(); tick(1);
        set_wb(1, 5); tick(1);
        idle(); tick(1);

        // RAW stall on r3, released by the same-cycle writeback.
        set_iss(1, 0, 0, 0, 0, 3, 1); tick(1);
        set_iss(1, 3, 1, 0, 0, 0, 0);
        repeat (3) tick(1);
        set_wb(1, 3); tick(1);
        idle(); tick(1);

        // Destination saturation on r7.
        repeat (3) begin set_iss(1, 0, 0, 0, 0, 7, 1); tick(1); end
        repeat (2) tick(1);
        set_wb(1, 7); tick(1);
        idle(); tick(1);
        repeat (3) begin set_wb(1, 7); tick(1); end
        idle(); tick(1);

        // Register 0 is invisible.
        repeat (4) begin set_iss(1, 0, 1, 0, 1, 0, 1); set_wb(1, 0); tick(1); end
        idle(); tick(1);

        // Illegal writeback sets the sticky error, cleared only by reset.
        set_wb(1, 9); tick(1);
        idle(); repeat (3) tick(1);
        do_reset();
        idle(); tick(1);

        // Random traffic on a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            int a;
            set_iss($urandom_range(0, 9) < 7,
                    $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            set_wb(0, 0);
            if ($urandom_range(0, 49) == 0) begin
                set_wb(1, $urandom_range(0, 15));
            end else if ($urandom_range(0, 2) != 0) begin
                a = $urandom_range(1, 15);
                for (int k = 0; k < 15; k++) begin
                    if (mcnt[a] != 0) begin
                        set_wb(1, a);
                        break;
                    end
                    a = (a % 15) + 1;
                end
            end
            tick(1);
        end
        idle(); tick(1);

        // Stall counter saturation, then asynchronous reset with the stall still held.
        do_reset();
        idle(); set_iss(1, 0, 0, 0, 0, 3, 1); tick(1);
        set_iss(1, 3, 1, 0, 0, 0, 0);
        for (int n = 0; n < 65545; n++) tick(n > 65525);
        do_reset();
        tick(1);
        idle(); tick(1);

        repeat (2) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d exp=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
